fifo_rd_sched: RTL and testbench

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/rd_ptr_empty.sv | 49 ++++
 rtl/fifo_rd_sched.sv | 130 +++++++++++++
 tb/tb_fifo_rd_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side scheduler.
// No logic of its own; the gray2bin helper is purely combinational.
// Backpressure: not applicable.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_W          = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } rd_state_t;

  // Gray to binary on a zero-extended 32-bit word; callers keep the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_empty.sv
// Read pointer (binary and Gray), empty flag and fill level of the FIFO.
// Pointers and rempty update one cycle after pop; rlevel is combinational.
// Backpressure: pointer advances only on pop, so a stalled reader holds raddr.
module rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_nxt;
  logic [PW-1:0] rgray_nxt;
  logic [31:0]   wbin_full;
  logic          unused_wbin_hi;

  assign rbin_nxt  = rbin + {{(PW-1){1'b0}}, pop};
  assign rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt;
  assign raddr     = rbin[ADDR_WIDTH-1:0];

  // Extra pointer bit makes the full-depth level distinct from zero.
  assign wbin_full      = gray2bin({{(32-PW){1'b0}}, rq2_wptr});
  assign rlevel         = wbin_full[PW-1:0] - rbin;
  assign unused_wbin_hi = ^wbin_full[31:PW];

  // Advance both pointer forms together and look ahead for empty.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbin_nxt;
      rptr   <= rgray_nxt;
      rempty <= (rgray_nxt == rq2_wptr);
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Two-consumer round-robin burst reader for the read side of an async FIFO.
// Grant and first beat appear one cycle after the request is eligible.
// Backpressure: dout_ready low stalls the beat; no pop, dout held stable.
module fifo_rd_sched
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            req,
  input  logic [2*LEN_W-1:0]    req_len,
  output logic [1:0]            gnt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   rlevel
);

  localparam int PW = ADDR_WIDTH + 1;

  rd_state_t        state, state_nxt;
  logic [1:0]       gnt_nxt;
  logic             valid_nxt;
  logic             last_nxt;
  logic [LEN_W-1:0] beat_cnt, beat_nxt;
  logic [LEN_W-1:0] blen, blen_nxt;
  logic             rr_ptr, rr_nxt;
  logic             pop;
  logic [1:0]       elig;
  logic [PW-1:0]    need0, need1;
  logic             win;
  logic [LEN_W-1:0] len_sel;

  assign pop  = dout_valid & dout_ready;
  assign dout = rdata;

  // A burst may only start once every word of it is already resident.
  assign need0   = PW'(req_len[LEN_W-1:0]) + PW'(1);
  assign need1   = PW'(req_len[2*LEN_W-1:LEN_W]) + PW'(1);
  assign elig[0] = req[0] && (rlevel >= need0);
  assign elig[1] = req[1] && (rlevel >= need1);

  rd_ptr_empty #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_ptr_empty (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .pop      (pop),
    .rq2_wptr (rq2_wptr),
    .rptr     (rptr),
    .raddr    (raddr),
    .rempty   (rempty),
    .rlevel   (rlevel)
  );

  // Arbitration, burst sequencing and next values of all scheduler registers.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    valid_nxt = dout_valid;
    last_nxt  = dout_last;
    beat_nxt  = beat_cnt;
    blen_nxt  = blen;
    rr_nxt    = rr_ptr;
    win       = 1'b0;
    len_sel   = '0;
    case (state)
      ST_IDLE: begin
        if (|elig) begin
          win       = (elig == 2'b11) ? rr_ptr : elig[1];
          len_sel   = win ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          state_nxt = ST_XFER;
          gnt_nxt   = win ? 2'b10 : 2'b01;
          blen_nxt  = len_sel;
          beat_nxt  = '0;
          valid_nxt = 1'b1;
          last_nxt  = (len_sel == '0);
        end
      end
      ST_XFER: begin
        if (pop) begin
          if (dout_last) begin
            state_nxt = ST_IDLE;
            gnt_nxt   = 2'b00;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            beat_nxt  = '0;
            rr_nxt    = ~gnt[1];
          end else begin
            beat_nxt  = beat_cnt + LEN_W'(1);
            last_nxt  = ((beat_cnt + LEN_W'(1)) == blen);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Scheduler registers; reset drops any burst in progress.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state      <= ST_IDLE;
      gnt        <= 2'b00;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      beat_cnt   <= '0;
      blen       <= '0;
      rr_ptr     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      dout_valid <= valid_nxt;
      dout_last  <= last_nxt;
      beat_cnt   <= beat_nxt;
      blen       <= blen_nxt;
      rr_ptr     <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: reset, level gating, round-robin,
// backpressure, pointer wrap and reset during a burst.
// Memory is modelled as rdata = 0xC0DE0000 | raddr.
module tb_fifo_rd_sched;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [PW-1:0] rq2_wptr;
  logic [PW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [1:0]    req;
  logic [5:0]    req_len;
  logic [1:0]    gnt;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          rempty;
  logic [PW-1:0] rlevel;

  int checks   = 0;
  int failures = 0;
  int rb       = 0;   // model of the binary read pointer
  int t;

  always #5 rclk = ~rclk;

  assign rdata = 32'hC0DE_0000 | {28'h0, raddr};

  fifo_rd_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rq2_wptr   (rq2_wptr),
    .rptr       (rptr),
    .raddr      (raddr),
    .rdata      (rdata),
    .req        (req),
    .req_len    (req_len),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .rempty     (rempty),
    .rlevel     (rlevel)
  );

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] x;
    x = b[PW-1:0];
    return x ^ (x >> 1);
  endfunction

  function automatic logic [31:0] exp_dat(input int b);
    logic [31:0] a;
    a = b;
    return 32'hC0DE_0000 | (a & 32'hF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic set_w(input int w);
    rq2_wptr = gray(w);
  endtask

  // Wait for a grant, then walk the burst beat by beat against the model.
  task automatic burst(input logic [1:0] g_exp, input int n, input bit stall, input bit clr);
    int k;
    logic [31:0] held;
    k = 0;
    while (gnt == 2'b00 && k < 20) begin
      step();
      k++;
    end
    chk("grant", {30'h0, gnt}, {30'h0, g_exp});
    if (gnt != 2'b00) begin
      if (clr) begin
        req     = 2'b00;
        req_len = 6'b000_000;
      end
      for (int b = 0; b < n; b++) begin
        if (stall) begin
          dout_ready = 1'b0;
          held       = dout;
          step();
          chk("stall_dout", dout, held);
          chk("stall_rptr", {27'h0, rptr}, {27'h0, gray(rb)});
          chk("stall_vld", {31'h0, dout_valid}, 32'd1);
          dout_ready = 1'b1;
        end
        chk("beat_vld", {31'h0, dout_valid}, 32'd1);
        chk("beat_dout", dout, exp_dat(rb));
        chk("beat_last", {31'h0, dout_last}, (b == n - 1) ? 32'd1 : 32'd0);
        step();
        rb++;
      end
      chk("end_gnt", {30'h0, gnt}, 32'd0);
      chk("end_vld", {31'h0, dout_valid}, 32'd0);
      chk("end_rptr", {27'h0, rptr}, {27'h0, gray(rb)});
    end
  endtask

  initial begin
    rrst_n     = 1'b0;
    req        = 2'b00;
    req_len    = 6'b000_000;
    dout_ready = 1'b1;
    set_w(0);

    // Reset state
    step();
    step();
    rrst_n = 1'b1;
    step();
    chk("rst_rempty", {31'h0, rempty}, 32'd1);
    chk("rst_rlevel", {27'h0, rlevel}, 32'd0);
    chk("rst_gnt", {30'h0, gnt}, 32'd0);
    chk("rst_rptr", {27'h0, rptr}, 32'd0);
    chk("rst_vld", {31'h0, dout_valid}, 32'd0);

    // Level gating: 3 words resident, 4 requested
    set_w(3);
    req     = 2'b01;
    req_len = 6'b000_011;
    step();
    step();
    step();
    chk("gate_rlevel", {27'h0, rlevel}, 32'd3);
    chk("gate_nognt", {30'h0, gnt}, 32'd0);
    set_w(4);
    step();
    chk("gate_gnt_next", {30'h0, gnt}, 32'd1);
    burst(2'b01, 4, 1'b0, 1'b1);
    chk("gate_rptr", {27'h0, rptr}, 32'b00110);
    chk("gate_rempty", {31'h0, rempty}, 32'd1);

    // Round-robin from a fresh pointer with a full FIFO
    rrst_n = 1'b0;
    req    = 2'b00;
    set_w(0);
    rb = 0;
    step();
    rrst_n = 1'b1;
    set_w(16);
    step();
    chk("rr_rlevel16", {27'h0, rlevel}, 32'd16);
    req     = 2'b11;
    req_len = 6'b001_001;
    burst(2'b01, 2, 1'b0, 1'b0);
    burst(2'b10, 2, 1'b0, 1'b0);
    burst(2'b01, 2, 1'b0, 1'b0);
    req = 2'b00;
    chk("rr_rlevel", {27'h0, rlevel}, 32'd10);

    // Backpressure on an 8-word burst; length changed after grant
    req     = 2'b01;
    req_len = 6'b000_111;
    burst(2'b01, 8, 1'b1, 1'b1);
    chk("bp_rlevel", {27'h0, rlevel}, 32'd2);

    // Bring read pointer to 30, then wrap through 31 -> 0 -> 2
    set_w(30);
    req     = 2'b10;
    req_len = 6'b111_000;
    burst(2'b10, 8, 1'b0, 1'b0);
    burst(2'b10, 8, 1'b0, 1'b1);
    chk("wrap_rptr30", {27'h0, rptr}, {27'h0, gray(30)});
    set_w(2);
    step();
    chk("wrap_rlevel", {27'h0, rlevel}, 32'd4);
    req     = 2'b01;
    req_len = 6'b000_011;
    burst(2'b01, 4, 1'b0, 1'b1);
    chk("wrap_rptr2", {27'h0, rptr}, 32'b00011);
    chk("wrap_rempty", {31'h0, rempty}, 32'd1);

    // Reset on beat 3 of an 8-word burst
    set_w(10);
    req     = 2'b01;
    req_len = 6'b000_111;
    t = 0;
    while (gnt == 2'b00 && t < 20) begin
      step();
      t++;
    end
    chk("mid_gnt", {30'h0, gnt}, 32'd1);
    req = 2'b00;
    step();
    step();
    chk("mid_beat3_dout", dout, exp_dat(rb + 2));
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {30'h0, gnt}, 32'd0);
    chk("mid_rst_vld", {31'h0, dout_valid}, 32'd0);
    chk("mid_rst_last", {31'h0, dout_last}, 32'd0);
    chk("mid_rst_rptr", {27'h0, rptr}, 32'd0);
    chk("mid_rst_rempty", {31'h0, rempty}, 32'd1);
    rb = 0;
    step();
    rrst_n = 1'b1;
    step();
    step();
    chk("post_rst_gnt", {30'h0, gnt}, 32'd0);
    chk("post_rst_rlevel", {27'h0, rlevel}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
